// File: rtl/noc_pkg.sv
// Shared NoC constants: flit width, flit type and default credit/FIFO sizing.
package noc_pkg;

    localparam int FLIT_W       = 16;
    localparam int DEF_CREDITS  = 4;
    localparam int DEF_TX_DEPTH = 4;
    localparam int DEF_RX_DEPTH = 4;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/flit_fifo.sv
// Show-ahead flit FIFO with occupancy count; data read combinationally from the head.
// No internal guarding: the owner must not push when full (unless popping) nor pop when empty.
module flit_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Explicit wrap so non-power-of-two depths use every slot.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/noc_local_ni.sv
// Local NI: core<->router flit bridge with credit-based TX and credit-returning RX, 1-cycle TX latency.
// TX stalls on zero credits; RX drops on overflow. Sticky err_o only with NOC_NI_CREDIT_CHECK_EN.
module noc_local_ni #(
    parameter  int FLIT_W   = noc_pkg::FLIT_W,
    parameter  int CREDITS  = noc_pkg::DEF_CREDITS,
    parameter  int TX_DEPTH = noc_pkg::DEF_TX_DEPTH,
    parameter  int RX_DEPTH = noc_pkg::DEF_RX_DEPTH,
    localparam int CNT_W    = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] core_tx_data_i,
    input  logic              core_tx_valid_i,
    output logic              core_tx_ready_o,
    output logic [FLIT_W-1:0] link_data_o,
    output logic              link_valid_o,
    input  logic              link_incr_i,
    input  logic [FLIT_W-1:0] link_data_i,
    input  logic              link_valid_i,
    output logic              link_incr_o,
    output logic [FLIT_W-1:0] core_rx_data_o,
    output logic              core_rx_valid_o,
    input  logic              core_rx_ready_i,
    output logic [CNT_W-1:0]  credit_cnt_o,
    output logic              err_o
);

    localparam int TXC_W = $clog2(TX_DEPTH + 1);
    localparam int RXC_W = $clog2(RX_DEPTH + 1);

    logic [TXC_W-1:0]  tx_count;
    logic [FLIT_W-1:0] tx_head;
    logic              tx_push;
    logic              tx_pop;
    logic              credit_full;
    logic              incr_ok;

    logic [RXC_W-1:0]  rx_count;
    logic              rx_full;
    logic              rx_push;
    logic              rx_pop;

    // Qualified by rst so the core sees not-ready throughout reset.
    assign core_tx_ready_o = rst && (tx_count != TXC_W'(TX_DEPTH));
    assign tx_push         = core_tx_valid_i && core_tx_ready_o;
    assign tx_pop          = (tx_count != '0) && (credit_cnt_o != '0);
    assign credit_full     = (credit_cnt_o == CNT_W'(CREDITS));
    assign incr_ok         = link_incr_i && !credit_full;

    flit_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (core_tx_data_i),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt_o <= CNT_W'(CREDITS);
            link_valid_o <= 1'b0;
            link_data_o  <= '0;
        end else begin
            link_valid_o <= tx_pop;
            if (tx_pop) link_data_o <= tx_head;
            if (tx_pop && !incr_ok)      credit_cnt_o <= credit_cnt_o - 1'b1;
            else if (!tx_pop && incr_ok) credit_cnt_o <= credit_cnt_o + 1'b1;
        end
    end

    assign core_rx_valid_o = (rx_count != '0);
    assign rx_full         = (rx_count == RXC_W'(RX_DEPTH));
    assign rx_pop          = core_rx_valid_o && core_rx_ready_i;
    assign rx_push         = link_valid_i && (!rx_full || rx_pop);

    flit_fifo #(.W(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (link_data_i),
        .pop       (rx_pop),
        .head      (core_rx_data_o),
        .count     (rx_count)
    );

    // Each consumed flit frees one router-side buffer slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) link_incr_o <= 1'b0;
        else      link_incr_o <= rx_pop;
    end

`ifdef NOC_NI_CREDIT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_q | (link_incr_i && credit_full)
                                 | (link_valid_i && rx_full && !rx_pop);
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/noc_local_ni.md
NOC_LOCAL_NI -- requirements
Module: noc_local_ni

Interface
REQ-001 SHALL have parameter FLIT_W, default 16, flit width.
REQ-002 SHALL have parameter CREDITS, default 4, router input-buffer depth, which is the initial TX credit count.
REQ-003 SHALL have parameter TX_DEPTH, default 4, and parameter RX_DEPTH, default 4; RX_DEPTH SHALL be >= credits the router holds for this port.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: core_tx_data_i  in  FLIT_W  flit from core; core_tx_valid_i  in  1  core offers flit; core_tx_ready_o  out  1  NI accepts flit.
REQ-006 SHALL have ports: link_data_o  out  FLIT_W  flit to router local input; link_valid_o  out  1  flit valid; link_incr_i  in  1  credit return pulse from router.
REQ-007 SHALL have ports: link_data_i  in  FLIT_W  flit from router local output; link_valid_i  in  1  flit valid; link_incr_o  out  1  credit return pulse to router.
REQ-008 SHALL have ports: core_rx_data_o  out  FLIT_W  flit to core; core_rx_valid_o  out  1  flit available; core_rx_ready_i  in  1  core consumes.
REQ-009 SHALL have ports: credit_cnt_o  out  $clog2(CREDITS+1)  current TX credits; err_o  out  1  sticky protocol error.

Function
REQ-010 SHALL push core_tx_data_i into the TX FIFO when core_tx_valid_i && core_tx_ready_o; core_tx_ready_o = TX FIFO not full, with no bypass when full.
REQ-011 SHALL, in a cycle where the TX FIFO is non-empty and the credit count > 0, pop the head and register it to link_data_o with link_valid_o=1 on the next edge, sending at most one flit per cycle.
REQ-012 SHALL give minimum TX latency of 1 cycle: a flit pushed at edge N appears on the link after edge N+1.
REQ-013 SHALL drive link_valid_o as a 1-cycle pulse per flit; link_data_o holds its last value when link_valid_o=0.
REQ-014 SHALL update the credit counter as follows: send only -1; link_incr_i only +1; send and incr in the same cycle, unchanged.
REQ-015 SHALL ignore link_incr_i when the credit count == CREDITS (saturate) and flag an error (REQ-024).
REQ-016 SHALL write link_data_i into the RX FIFO when link_valid_i=1, if not full or if a core pop occurs in the same cycle.
REQ-017 SHALL drop a flit arriving on a full RX FIFO with no same-cycle pop, and flag an error.
REQ-018 SHALL drive core_rx_valid_o = RX FIFO not empty, with core_rx_data_o = head (show-ahead); pop on core_rx_valid_o && core_rx_ready_i.
REQ-019 SHALL pulse link_incr_o for exactly one cycle, registered one cycle after each RX pop; one pulse per popped flit.
REQ-020 SHALL wrap FIFO pointers modulo depth; full/empty SHALL be derived from an occupancy count, with no lost slot.

Reset
REQ-021 SHALL, while rst=0 (asynchronous), hold: FIFOs empty, credit count = CREDITS, link_valid_o=0, link_data_o=0, link_incr_o=0, core_rx_valid_o=0, core_tx_ready_o=0, err_o=0.
REQ-022 SHALL assert core_tx_ready_o in the first cycle after rst deasserts; flits in flight at reset SHALL be discarded.

Configuration
REQ-023 SHALL use macro NOC_NI_CREDIT_CHECK_EN to gate error detection.
REQ-024 SHALL, with NOC_NI_CREDIT_CHECK_EN defined, set err_o on incr at full credits (REQ-015) or RX overflow drop (REQ-017); err_o stays set until reset.
REQ-025 SHALL, without NOC_NI_CREDIT_CHECK_EN, tie err_o to 0 while saturation and drop behaviour are unchanged.

Structure
REQ-026 SHALL take FLIT_W, the flit_t typedef and the default CREDITS/TX_DEPTH/RX_DEPTH constants from shared package noc_pkg.
REQ-027 SHALL implement both FIFOs by instantiating one sub-module flit_fifo (parameterised depth, show-ahead, count output).

Verification
REQ-028 SHALL verify credit exhaustion: push 6 flits 0x0001..0x0006 with no incr; exactly 4 link_valid_o pulses, credit_cnt_o=0, and 2 flits remain queued.
REQ-029 SHALL verify credit resume: after REQ-028, pulse link_incr_i twice; 0x0005 then 0x0006 are sent on consecutive cycles after each credit, and credit_cnt_o returns to 0.
REQ-030 SHALL verify simultaneous events: send and incr in the same cycle at credit_cnt_o=2; credit_cnt_o stays 2.
REQ-031 SHALL verify RX path: inject 4 flits 0xA000..0xA003 with core_rx_ready_i=0, then raise ready; the core gets them in order and 4 link_incr_o pulses appear, each 1 cycle after its pop.
REQ-032 SHALL verify RX overflow: with RX full and no pop, inject a 5th flit 0xBEEF; it is dropped, and err_o=1 only when NOC_NI_CREDIT_CHECK_EN is defined.
REQ-033 SHALL verify reset mid-operation: assert rst with 3 flits queued and credit_cnt_o=1; outputs take REQ-021 values immediately, and after release credit_cnt_o=4 and the FIFOs are empty.
